bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 16, the maximum number of ACCESS cycles before an access is aborted (legal range 2..255).
REQ-002 Port: clk  in  1  system clock; every register updates on its rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Ports: m0Req  in  1, m0We  in  1, m0Addr  in  32, m0WData  in  32; these are the master-0 (CPU data port) request, write-enable, address and write data.
REQ-005 Ports: m0Ready  out  1, m0RData  out  32, m0Err  out  1; these are the master-0 completion pulse, read data and timeout flag.
REQ-006 Ports: m1Req, m1We, m1Addr, m1WData, m1Ready, m1RData, m1Err; these are the master-1 (DMA/debug) equivalents, with the same directions and widths.
REQ-007 Ports: busReq  out  1  access valid; busWe  out  1; busAddr  out  32; busWData  out  32.
REQ-008 Ports: busRData  in  32  slave read data; busReady  in  1  slave completion, sampled only in ACCESS.
REQ-009 Port: owner  out  1; it carries the index of the master currently granted, and is meaningful only in ACCESS and DONE.
REQ-010 Clock and reset are fixed: one clock, clk; reset is synchronous and active-high, named reset.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, ACCESS and DONE.
REQ-012 IDLE, with no request pending, SHALL hold IDLE.
REQ-013 IDLE with any mXReq=1 SHALL move to ACCESS on the next edge, latching the winner's We, Addr and WData and setting owner.
REQ-014 Arbitration SHALL be round-robin:
- if both masters request in the same IDLE cycle, the master that is not lastOwner wins;
- a single requester always wins.
REQ-015 ACCESS SHALL drive busReq=1, plus busWe, busAddr and busWData from the latched registers.
- These outputs SHALL stay stable for the whole ACCESS state.
REQ-016 ACCESS with busReady=1 SHALL capture busRData, clear the error flag, set lastOwner=owner, and move to DONE.
REQ-017 An ACCESS wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle with busReady=0.
REQ-018 ACCESS with busReady=0 and counter==TIMEOUT-1 SHALL abort to DONE, with captured rdata=0, the error flag set, and lastOwner=owner.
REQ-019 DONE SHALL last exactly one cycle, then return to IDLE.
- DONE SHALL pulse the owner's mXReady=1 and the owner's mXErr=error flag.
- The non-owner's Ready and Err SHALL stay 0.
REQ-020 mXRData SHALL present the captured rdata continuously from DONE until the next capture, for both masters.
REQ-021 Outside ACCESS, busReq and busWe SHALL be 0, and busAddr and busWData SHALL hold their last latched values.
REQ-022 Latency:
- minimum 3 cycles, from request sampled in IDLE (cycle 0) to mXReady high (cycle 2), when busReady=1 in the first ACCESS cycle;
- each busReady=0 cycle adds 1.
REQ-023 Handshake: a master SHALL hold Req, We, Addr and WData stable until Ready.
- A Req still high in the IDLE cycle after its Ready SHALL be treated as a new transaction.
REQ-024 Requests arriving during ACCESS or DONE SHALL be held off; there is no preemption and no queueing beyond the Req level.
REQ-025 If a master drops Req mid-ACCESS, the transaction SHALL still complete and Ready SHALL still pulse.
REQ-026 busReady SHALL be ignored in IDLE and DONE.

Reset
REQ-027 Reset SHALL force state=IDLE, owner=0, lastOwner=1 (so master 0 wins the first contention), counter=0 and error flag=0.
- The latched addr, wdata and rdata registers SHALL reset to 0, and We to 0.
REQ-028 Reset asserted in ACCESS or DONE SHALL abort the transaction immediately.
- No mXReady pulse SHALL follow, and bus outputs SHALL read 0 or inactive on the cycle after the reset edge.

Verification
REQ-029 Single read: m0Req=1, m0We=0, m0Addr=0x1000_0004, with busReady=1 on the first ACCESS cycle and busRData=0xCAFE_0001.
- Required: busReq high for exactly 1 cycle with busAddr=0x1000_0004 and busWe=0.
- Required: m0Ready high 2 cycles after the request was sampled, m0RData=0xCAFE_0001, m0Err=0.
REQ-030 Contention: m0 and m1 request together from reset, with busReady=1 immediately, and both keep requesting.
- Required: grants go m0, m1, m0, m1; each Ready pulses once per grant.
REQ-031 Wait states: m1 writes 0x55AA_55AA to 0x2000_0000, with busReady low for 3 cycles.
- Required: ACCESS lasts 4 cycles with stable bus outputs and busWe=1; then m1Ready=1 and m1Err=0.
REQ-032 Timeout: TIMEOUT=16, busReady held 0.
- Required: busReq high for exactly 16 cycles; then mXReady=1 with mXErr=1 and mXRData=0; FSM back in IDLE.
REQ-033 Reset mid-access: reset asserted on the 2nd ACCESS cycle.
- Required: next cycle shows busReq=0, busWe=0, no Ready pulse.
- Required: with m0 and m1 then both requesting, m0 is granted first.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter.
// A granted master's request is latched, placed on the bus for the ACCESS
// phase, and completed by a single DONE cycle. The DONE cycle pulses that
// master's ready and, if the slave never answered, its error flag.
module bus_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0Req,
  input  logic        m0We,
  input  logic [31:0] m0Addr,
  input  logic [31:0] m0WData,
  output logic        m0Ready,
  output logic [31:0] m0RData,
  output logic        m0Err,
  input  logic        m1Req,
  input  logic        m1We,
  input  logic [31:0] m1Addr,
  input  logic [31:0] m1WData,
  output logic        m1Ready,
  output logic [31:0] m1RData,
  output logic        m1Err,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [31:0] busWData,
  input  logic [31:0] busRData,
  input  logic        busReady,
  output logic        owner
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic        owner_r;
  logic        last_owner_r;
  logic        we_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [31:0] rdata_r;
  logic        err_r;
  logic [7:0]  cnt_r;

  logic        any_req_s;
  logic        grant_s;
  logic        timeout_s;

  // Round-robin winner: under contention the master that did not own the
  // bus last time wins; a lone requester always wins.
  always_comb begin
    any_req_s = m0Req | m1Req;
    timeout_s = (cnt_r == 8'(TIMEOUT - 1));
    if (m0Req && m1Req) begin
      grant_s = ~last_owner_r;
    end else if (m1Req) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; busReady only matters while in ACCESS.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          next_state_s = ACCESS;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS: begin
        if (busReady || timeout_s) begin
          next_state_s = DONE;
        end else begin
          next_state_s = ACCESS;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Request latching, wait counter, read-data capture and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r      <= 1'b0;
      last_owner_r <= 1'b1;
      we_r         <= 1'b0;
      addr_r       <= 32'd0;
      wdata_r      <= 32'd0;
      rdata_r      <= 32'd0;
      err_r        <= 1'b0;
      cnt_r        <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            owner_r <= grant_s;
            we_r    <= grant_s ? m1We    : m0We;
            addr_r  <= grant_s ? m1Addr  : m0Addr;
            wdata_r <= grant_s ? m1WData : m0WData;
            cnt_r   <= 8'd0;
          end
        end
        ACCESS: begin
          if (busReady) begin
            rdata_r      <= busRData;
            err_r        <= 1'b0;
            last_owner_r <= owner_r;
          end else if (timeout_s) begin
            rdata_r      <= 32'd0;
            err_r        <= 1'b1;
            last_owner_r <= owner_r;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  // Output decode from registered state; bus address/data simply hold the
  // last latched request outside ACCESS.
  always_comb begin
    busReq   = (state_r == ACCESS);
    busWe    = (state_r == ACCESS) & we_r;
    busAddr  = addr_r;
    busWData = wdata_r;
    m0Ready  = (state_r == DONE) & ~owner_r;
    m1Ready  = (state_r == DONE) &  owner_r;
    m0Err    = (state_r == DONE) & ~owner_r & err_r;
    m1Err    = (state_r == DONE) &  owner_r & err_r;
    m0RData  = rdata_r;
    m1RData  = rdata_r;
    owner    = owner_r;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: single read, contention, wait states,
// timeout and reset in the middle of an access.
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0Req, m0We, m1Req, m1We;
  logic [31:0] m0Addr, m0WData, m1Addr, m1WData;
  logic        m0Ready, m0Err, m1Ready, m1Err;
  logic [31:0] m0RData, m1RData;
  logic        busReq, busWe, busReady, owner;
  logic [31:0] busAddr, busWData, busRData;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .m0Req(m0Req), .m0We(m0We), .m0Addr(m0Addr), .m0WData(m0WData),
    .m0Ready(m0Ready), .m0RData(m0RData), .m0Err(m0Err),
    .m1Req(m1Req), .m1We(m1We), .m1Addr(m1Addr), .m1WData(m1WData),
    .m1Ready(m1Ready), .m1RData(m1RData), .m1Err(m1Err),
    .busReq(busReq), .busWe(busWe), .busAddr(busAddr), .busWData(busWData),
    .busRData(busRData), .busReady(busReady), .owner(owner)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle; outputs are checked, then inputs changed.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    m0Req = 1'b0; m0We = 1'b0; m0Addr = 32'd0; m0WData = 32'd0;
    m1Req = 1'b0; m1We = 1'b0; m1Addr = 32'd0; m1WData = 32'd0;
    busReady = 1'b0; busRData = 32'd0;
    tick(); tick();
    check("rst_busReq", {31'd0, busReq}, 32'd0);
    check("rst_busAddr", busAddr, 32'd0);
    check("rst_owner", {31'd0, owner}, 32'd0);
    check("rst_m0RData", m0RData, 32'd0);
    check("rst_m0Ready", {31'd0, m0Ready}, 32'd0);
    reset = 1'b0;
    tick();

    // Single read by m0 with an immediate slave response.
    m0Req = 1'b1; m0We = 1'b0; m0Addr = 32'h1000_0004;
    busReady = 1'b1; busRData = 32'hCAFE_0001;
    tick();
    check("rd_busReq", {31'd0, busReq}, 32'd1);
    check("rd_busAddr", busAddr, 32'h1000_0004);
    check("rd_busWe", {31'd0, busWe}, 32'd0);
    check("rd_m0Ready_early", {31'd0, m0Ready}, 32'd0);
    tick();
    check("rd_busReq_done", {31'd0, busReq}, 32'd0);
    check("rd_m0Ready", {31'd0, m0Ready}, 32'd1);
    check("rd_m0RData", m0RData, 32'hCAFE_0001);
    check("rd_m0Err", {31'd0, m0Err}, 32'd0);
    check("rd_m1Ready", {31'd0, m1Ready}, 32'd0);
    m0Req = 1'b0;
    tick();
    check("rd_idle_ready", {31'd0, m0Ready}, 32'd0);
    check("rd_hold_rdata", m0RData, 32'hCAFE_0001);

    // Contention from reset: grants alternate m0, m1, m0, m1.
    reset = 1'b1; tick(); reset = 1'b0;
    m0Req = 1'b1; m0Addr = 32'h0000_00A0;
    m1Req = 1'b1; m1Addr = 32'h0000_00B0; m1We = 1'b0;
    busReady = 1'b1; busRData = 32'h1234_5678;
    for (int g = 0; g < 4; g++) begin
      tick();
      check($sformatf("ct%0d_owner", g), {31'd0, owner}, 32'(g % 2));
      check($sformatf("ct%0d_addr", g), busAddr, (g % 2) ? 32'h0000_00B0 : 32'h0000_00A0);
      tick();
      check($sformatf("ct%0d_m0Ready", g), {31'd0, m0Ready}, (g % 2) ? 32'd0 : 32'd1);
      check($sformatf("ct%0d_m1Ready", g), {31'd0, m1Ready}, (g % 2) ? 32'd1 : 32'd0);
      tick();
      check($sformatf("ct%0d_idle", g), {31'd0, m0Ready | m1Ready | busReq}, 32'd0);
    end
    m0Req = 1'b0; m1Req = 1'b0;
    tick();

    // m1 write with three wait states.
    m1Req = 1'b1; m1We = 1'b1; m1Addr = 32'h2000_0000; m1WData = 32'h55AA_55AA;
    busReady = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ws%0d_busReq", i), {31'd0, busReq}, 32'd1);
      check($sformatf("ws%0d_busWe", i), {31'd0, busWe}, 32'd1);
      check($sformatf("ws%0d_addr", i), busAddr, 32'h2000_0000);
      check($sformatf("ws%0d_wdata", i), busWData, 32'h55AA_55AA);
      check($sformatf("ws%0d_m1Ready", i), {31'd0, m1Ready}, 32'd0);
      if (i == 3) busReady = 1'b1;
      tick();
    end
    check("ws_m1Ready", {31'd0, m1Ready}, 32'd1);
    check("ws_m1Err", {31'd0, m1Err}, 32'd0);
    check("ws_busWe_done", {31'd0, busWe}, 32'd0);
    m1Req = 1'b0; m1We = 1'b0;
    busReady = 1'b0;
    tick();

    // Timeout: slave never answers, m0 read aborts after 16 ACCESS cycles.
    m0Req = 1'b1; m0We = 1'b0; m0Addr = 32'h3000_0010;
    tick();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (busReq) begin
        cnt++;
        tick();
      end
    end
    check("to_cycles", 32'(cnt), 32'd16);
    check("to_m0Ready", {31'd0, m0Ready}, 32'd1);
    check("to_m0Err", {31'd0, m0Err}, 32'd1);
    check("to_m0RData", m0RData, 32'd0);
    check("to_m1Err", {31'd0, m1Err}, 32'd0);
    m0Req = 1'b0;
    tick();
    check("to_idle_busReq", {31'd0, busReq}, 32'd0);
    check("to_idle_err", {31'd0, m0Err | m0Ready}, 32'd0);

    // Reset on the second ACCESS cycle of an m1 write.
    m1Req = 1'b1; m1We = 1'b1; m1Addr = 32'h4000_0000; m1WData = 32'h0BAD_F00D;
    tick();
    check("rm_busReq_a1", {31'd0, busReq}, 32'd1);
    tick();
    check("rm_busWe_a2", {31'd0, busWe}, 32'd1);
    reset = 1'b1;
    tick();
    check("rm_busReq", {31'd0, busReq}, 32'd0);
    check("rm_busWe", {31'd0, busWe}, 32'd0);
    check("rm_busAddr", busAddr, 32'd0);
    check("rm_ready", {31'd0, m0Ready | m1Ready}, 32'd0);
    reset = 1'b0;
    m0Req = 1'b1; m0We = 1'b0; m0Addr = 32'h5000_0000;
    tick();
    check("rm_ready_after", {31'd0, m0Ready | m1Ready}, 32'd0);
    check("rm_grant_busReq", {31'd0, busReq}, 32'd1);
    check("rm_grant_owner", {31'd0, owner}, 32'd0);
    check("rm_grant_addr", busAddr, 32'h5000_0000);
    m0Req = 1'b0; m1Req = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
